// File: rtl/id_ex_stage.sv
// Decode-to-execute pipeline register with operand forwarding, load-use bubbles and flush.
// 1-cycle id->ex latency; holds all ex_* while execute deasserts ex_ready, raising stall_id to freeze decode.
module id_ex_stage #(
    parameter int CTRL_W      = 8,
    parameter int STALL_CNT_W = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   id_valid,
    input  logic [4:0]             id_rs_addr,
    input  logic [4:0]             id_rt_addr,
    input  logic [4:0]             id_rd_addr,
    input  logic [31:0]            id_rs_data,
    input  logic [31:0]            id_rt_data,
    input  logic [31:0]            id_imm,
    input  logic [31:0]            id_pc,
    input  logic [1:0]             id_jump,
    input  logic [CTRL_W-1:0]      id_ctrl,
    input  logic                   id_reg_write,
    input  logic                   id_mem_read,
    input  logic                   exmem_reg_write,
    input  logic                   exmem_mem_read,
    input  logic [4:0]             exmem_rd,
    input  logic [31:0]            exmem_result,
    input  logic                   memwb_reg_write,
    input  logic [4:0]             memwb_rd,
    input  logic [31:0]            memwb_result,
    input  logic                   flush,
    input  logic                   ex_ready,
    output logic                   stall_id,
    output logic                   ex_valid,
    output logic [31:0]            ex_rs_val,
    output logic [31:0]            ex_rt_val,
    output logic [4:0]             ex_rs_addr,
    output logic [4:0]             ex_rt_addr,
    output logic [4:0]             ex_rd_addr,
    output logic [31:0]            ex_imm,
    output logic [31:0]            ex_pc,
    output logic [1:0]             ex_jump,
    output logic [CTRL_W-1:0]      ex_ctrl,
    output logic                   ex_reg_write,
    output logic                   ex_mem_read,
    output logic [STALL_CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {RUN, BUBBLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic                   valid_q, valid_d;
    logic [31:0]            rs_val_q, rs_val_d, rt_val_q, rt_val_d;
    logic [4:0]             rs_addr_q, rs_addr_d, rt_addr_q, rt_addr_d, rd_addr_q, rd_addr_d;
    logic [31:0]            imm_q, imm_d, pc_q, pc_d;
    logic [1:0]             jump_q, jump_d;
    logic [CTRL_W-1:0]      ctrl_q, ctrl_d;
    logic                   reg_write_q, reg_write_d, mem_read_q, mem_read_d;
    logic [STALL_CNT_W-1:0] cnt_q, cnt_d;

    logic        is_jal;
    logic [31:0] rs_fwd, rt_fwd;
    logic        ld_in_ex, ld_in_mem, rs_haz, rt_haz, hazard, ex_busy;

    assign is_jal = (id_jump == 2'b11);

    // A jal carries its target in rs_data, so that operand is never replaced.
    always_comb begin
        rs_fwd = id_rs_data;
        rt_fwd = id_rt_data;
        if (!is_jal && id_rs_addr != 5'd0) begin
            if (exmem_reg_write && !exmem_mem_read && exmem_rd == id_rs_addr)
                rs_fwd = exmem_result;
            else if (memwb_reg_write && memwb_rd == id_rs_addr)
                rs_fwd = memwb_result;
        end
        if (id_rt_addr != 5'd0) begin
            if (exmem_reg_write && !exmem_mem_read && exmem_rd == id_rt_addr)
                rt_fwd = exmem_result;
            else if (memwb_reg_write && memwb_rd == id_rt_addr)
                rt_fwd = memwb_result;
        end
    end

    assign ld_in_ex  = valid_q && mem_read_q;
    assign ld_in_mem = exmem_mem_read && exmem_reg_write;
    assign rs_haz    = !is_jal && id_rs_addr != 5'd0 &&
                       ((ld_in_ex && rd_addr_q == id_rs_addr) || (ld_in_mem && exmem_rd == id_rs_addr));
    assign rt_haz    = id_rt_addr != 5'd0 &&
                       ((ld_in_ex && rd_addr_q == id_rt_addr) || (ld_in_mem && exmem_rd == id_rt_addr));
    assign hazard    = id_valid && (rs_haz || rt_haz);
    assign ex_busy   = valid_q && !ex_ready;
    assign stall_id  = (hazard || ex_busy) && !flush;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        rs_val_d    = rs_val_q;
        rt_val_d    = rt_val_q;
        rs_addr_d   = rs_addr_q;
        rt_addr_d   = rt_addr_q;
        rd_addr_d   = rd_addr_q;
        imm_d       = imm_q;
        pc_d        = pc_q;
        jump_d      = jump_q;
        ctrl_d      = ctrl_q;
        reg_write_d = reg_write_q;
        mem_read_d  = mem_read_q;
        cnt_d       = cnt_q;

        // A held instruction survives flush; only ex_ready releases it.
        if (state_q == HOLD && !ex_ready) begin
            state_d = HOLD;
        end else if (flush) begin
            state_d     = RUN;
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
        end else if (ex_busy) begin
            state_d = HOLD;
        end else if (hazard) begin
            state_d     = BUBBLE;
            valid_d     = 1'b0;
            reg_write_d = 1'b0;
            mem_read_d  = 1'b0;
            if (cnt_q != '1)
                cnt_d = cnt_q + STALL_CNT_W'(1);
        end else begin
            state_d     = RUN;
            valid_d     = id_valid;
            rs_val_d    = rs_fwd;
            rt_val_d    = rt_fwd;
            rs_addr_d   = id_rs_addr;
            rt_addr_d   = id_rt_addr;
            rd_addr_d   = id_rd_addr;
            imm_d       = id_imm;
            pc_d        = id_pc;
            jump_d      = id_jump;
            ctrl_d      = id_ctrl;
            reg_write_d = id_valid && id_reg_write;
            mem_read_d  = id_valid && id_mem_read;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= RUN;
            valid_q     <= 1'b0;
            rs_val_q    <= '0;
            rt_val_q    <= '0;
            rs_addr_q   <= '0;
            rt_addr_q   <= '0;
            rd_addr_q   <= '0;
            imm_q       <= '0;
            pc_q        <= '0;
            jump_q      <= '0;
            ctrl_q      <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            rs_val_q    <= rs_val_d;
            rt_val_q    <= rt_val_d;
            rs_addr_q   <= rs_addr_d;
            rt_addr_q   <= rt_addr_d;
            rd_addr_q   <= rd_addr_d;
            imm_q       <= imm_d;
            pc_q        <= pc_d;
            jump_q      <= jump_d;
            ctrl_q      <= ctrl_d;
            reg_write_q <= reg_write_d;
            mem_read_q  <= mem_read_d;
            cnt_q       <= cnt_d;
        end
    end

    assign ex_valid     = valid_q;
    assign ex_rs_val    = rs_val_q;
    assign ex_rt_val    = rt_val_q;
    assign ex_rs_addr   = rs_addr_q;
    assign ex_rt_addr   = rt_addr_q;
    assign ex_rd_addr   = rd_addr_q;
    assign ex_imm       = imm_q;
    assign ex_pc        = pc_q;
    assign ex_jump      = jump_q;
    assign ex_ctrl      = ctrl_q;
    assign ex_reg_write = reg_write_q;
    assign ex_mem_read  = mem_read_q;
    assign stall_count  = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: forwarding vector table plus hazard, hold, flush, saturation and reset sequences.
module tb_id_ex_stage;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        id_valid;
    logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
    logic [31:0] id_rs_data, id_rt_data, id_imm, id_pc;
    logic [1:0]  id_jump;
    logic [7:0]  id_ctrl;
    logic        id_reg_write, id_mem_read;
    logic        exmem_reg_write, exmem_mem_read;
    logic [4:0]  exmem_rd;
    logic [31:0] exmem_result;
    logic        memwb_reg_write;
    logic [4:0]  memwb_rd;
    logic [31:0] memwb_result;
    logic        flush, ex_ready;
    logic        stall_id, ex_valid;
    logic [31:0] ex_rs_val, ex_rt_val, ex_imm, ex_pc;
    logic [4:0]  ex_rs_addr, ex_rt_addr, ex_rd_addr;
    logic [1:0]  ex_jump;
    logic [7:0]  ex_ctrl;
    logic        ex_reg_write, ex_mem_read;
    logic [2:0]  stall_count;

    int errors = 0;
    int checks = 0;

    id_ex_stage #(.CTRL_W(8), .STALL_CNT_W(3)) dut (
        .clock(clock), .reset_n(reset_n), .id_valid(id_valid),
        .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm), .id_pc(id_pc),
        .id_jump(id_jump), .id_ctrl(id_ctrl), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .exmem_reg_write(exmem_reg_write), .exmem_mem_read(exmem_mem_read),
        .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .flush(flush), .ex_ready(ex_ready), .stall_id(stall_id), .ex_valid(ex_valid),
        .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_rs_addr(ex_rs_addr),
        .ex_rt_addr(ex_rt_addr), .ex_rd_addr(ex_rd_addr), .ex_imm(ex_imm), .ex_pc(ex_pc),
        .ex_jump(ex_jump), .ex_ctrl(ex_ctrl), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .stall_count(stall_count)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  rs_a, rt_a;
        logic [31:0] rs_d, rt_d;
        logic [1:0]  jump;
        logic        xm_rw, xm_mr;
        logic [4:0]  xm_rd;
        logic [31:0] xm_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic        exp_stall;
        logic [31:0] exp_rs, exp_rt;
    } vec_t;

    vec_t vec [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [1:0] jmp,
                          input logic mr);
        id_valid     = v;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        id_rd_addr   = rd;
        id_rs_data   = rsd;
        id_rt_data   = rtd;
        id_jump      = jmp;
        id_mem_read  = mr;
        id_reg_write = 1'b1;
        id_imm       = {27'd0, rd};
        id_pc        = 32'h100;
        id_ctrl      = 8'h5A;
    endtask

    task automatic set_fwd(input logic xrw, input logic xmr, input logic [4:0] xrd, input logic [31:0] xres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        exmem_reg_write = xrw;
        exmem_mem_read  = xmr;
        exmem_rd        = xrd;
        exmem_result    = xres;
        memwb_reg_write = wrw;
        memwb_rd        = wrd;
        memwb_result    = wres;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    initial begin
        vec[0] = '{5'd1,  5'd2,  32'h11,       32'h22, 2'b00, 1'b1, 1'b0, 5'd9,  32'h9999, 1'b0, 5'd0,  32'h0,    1'b0, 32'h11,       32'h22};
        vec[1] = '{5'd3,  5'd5,  32'h33,       32'h55, 2'b00, 1'b1, 1'b0, 5'd3,  32'h10,   1'b0, 5'd0,  32'h0,    1'b0, 32'h10,       32'h55};
        vec[2] = '{5'd7,  5'd7,  32'h70,       32'h71, 2'b00, 1'b1, 1'b0, 5'd7,  32'hAA,   1'b1, 5'd7,  32'hBB,   1'b0, 32'hAA,       32'hAA};
        vec[3] = '{5'd8,  5'd9,  32'h80,       32'h90, 2'b00, 1'b1, 1'b0, 5'd8,  32'hC0,   1'b1, 5'd9,  32'h99,   1'b0, 32'hC0,       32'h99};
        vec[4] = '{5'd0,  5'd0,  32'h5,        32'h0,  2'b00, 1'b1, 1'b0, 5'd0,  32'hFFFF, 1'b1, 5'd0,  32'hEEEE, 1'b0, 32'h5,        32'h0};
        vec[5] = '{5'd6,  5'd10, 32'h60,       32'hA0, 2'b00, 1'b1, 1'b1, 5'd4,  32'h44,   1'b1, 5'd6,  32'h66,   1'b0, 32'h66,       32'hA0};
        vec[6] = '{5'd3,  5'd3,  32'h00400010, 32'h30, 2'b11, 1'b1, 1'b0, 5'd3,  32'h77,   1'b0, 5'd0,  32'h0,    1'b0, 32'h00400010, 32'h77};
        vec[7] = '{5'd3,  5'd4,  32'h00400010, 32'h40, 2'b11, 1'b1, 1'b1, 5'd3,  32'h77,   1'b0, 5'd0,  32'h0,    1'b0, 32'h00400010, 32'h40};
        vec[8] = '{5'd12, 5'd13, 32'hC,        32'hD,  2'b00, 1'b0, 1'b0, 5'd12, 32'hDEAD, 1'b0, 5'd0,  32'h0,    1'b0, 32'hC,        32'hD};
        vec[9] = '{5'd14, 5'd15, 32'hE,        32'hF,  2'b00, 1'b0, 1'b0, 5'd0,  32'h0,    1'b0, 5'd14, 32'h1414, 1'b0, 32'hE,        32'hF};

        reset_n = 1'b0;
        flush = 1'b0;
        ex_ready = 1'b1;
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 2'b00, 1'b0);
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        repeat (2) tick;
        chk("reset_ex_valid", 32'(ex_valid), 32'd0);
        chk("reset_rs_val", ex_rs_val, 32'd0);
        chk("reset_reg_write", 32'(ex_reg_write), 32'd0);
        chk("reset_stall_count", 32'(stall_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            set_id(1'b1, vec[i].rs_a, vec[i].rt_a, 5'(16 + i), vec[i].rs_d, vec[i].rt_d, vec[i].jump, 1'b0);
            set_fwd(vec[i].xm_rw, vec[i].xm_mr, vec[i].xm_rd, vec[i].xm_res,
                    vec[i].wb_rw, vec[i].wb_rd, vec[i].wb_res);
            #1;
            chk($sformatf("v%0d_stall_id", i), 32'(stall_id), 32'(vec[i].exp_stall));
            tick;
            chk($sformatf("v%0d_ex_valid", i), 32'(ex_valid), 32'd1);
            chk($sformatf("v%0d_rs_val", i), ex_rs_val, vec[i].exp_rs);
            chk($sformatf("v%0d_rt_val", i), ex_rt_val, vec[i].exp_rt);
            chk($sformatf("v%0d_rd_addr", i), 32'(ex_rd_addr), 32'(16 + i));
        end
        chk("table_stall_count", 32'(stall_count), 32'd0);

        // Load in EX/MEM feeding the decoded add: one bubble, then MEM/WB forward.
        @(negedge clock);
        set_id(1'b1, 5'd8, 5'd1, 5'd10, 32'h0, 32'h1, 2'b00, 1'b0);
        set_fwd(1'b1, 1'b1, 5'd8, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 chk("lu_stall_id", 32'(stall_id), 32'd1);
        tick;
        chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
        chk("lu_bubble_rw", 32'(ex_reg_write), 32'd0);
        chk("lu_stall_count", 32'(stall_count), 32'd1);
        @(negedge clock);
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd8, 32'h1234);
        #1 chk("lu_release_stall", 32'(stall_id), 32'd0);
        tick;
        chk("lu_add_valid", 32'(ex_valid), 32'd1);
        chk("lu_add_rs", ex_rs_val, 32'h1234);
        chk("lu_count_kept", 32'(stall_count), 32'd1);

        // Back-pressure: three held cycles, flush while held, then release with flush.
        @(negedge clock);
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd0, 5'd20, 32'h111, 32'h0, 2'b00, 1'b0);
        tick;
        chk("hold_capture", ex_rs_val, 32'h111);
        @(negedge clock);
        ex_ready = 1'b0;
        set_id(1'b1, 5'd2, 5'd0, 5'd21, 32'h222, 32'h0, 2'b00, 1'b0);
        for (int c = 0; c < 3; c++) begin
            #1 chk($sformatf("hold%0d_stall_id", c), 32'(stall_id), 32'd1);
            tick;
            chk($sformatf("hold%0d_rd", c), 32'(ex_rd_addr), 32'd20);
            chk($sformatf("hold%0d_rs", c), ex_rs_val, 32'h111);
            @(negedge clock);
        end
        flush = 1'b1;
        #1 chk("hold_flush_stall_id", 32'(stall_id), 32'd0);
        tick;
        chk("hold_flush_valid", 32'(ex_valid), 32'd1);
        chk("hold_flush_rd", 32'(ex_rd_addr), 32'd20);
        chk("hold_flush_rs", ex_rs_val, 32'h111);
        @(negedge clock);
        ex_ready = 1'b1;
        tick;
        chk("release_flush_valid", 32'(ex_valid), 32'd0);
        chk("release_flush_rw", 32'(ex_reg_write), 32'd0);
        @(negedge clock);
        flush = 1'b0;
        tick;
        chk("after_hold_rd", 32'(ex_rd_addr), 32'd21);
        chk("after_hold_rs", ex_rs_val, 32'h222);

        // Hazard coinciding with flush: flush wins, nothing counted.
        @(negedge clock);
        set_id(1'b1, 5'd8, 5'd0, 5'd22, 32'h0, 32'h0, 2'b00, 1'b0);
        set_fwd(1'b1, 1'b1, 5'd8, 32'h0, 1'b0, 5'd0, 32'h0);
        flush = 1'b1;
        #1 chk("hz_flush_stall_id", 32'(stall_id), 32'd0);
        tick;
        chk("hz_flush_valid", 32'(ex_valid), 32'd0);
        chk("hz_flush_count", 32'(stall_count), 32'd1);

        // Load captured here, consumer waits two cycles (EX then EX/MEM).
        @(negedge clock);
        flush = 1'b0;
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd1, 5'd0, 5'd9, 32'h0, 32'h0, 2'b00, 1'b1);
        tick;
        chk("lw_mem_read", 32'(ex_mem_read), 32'd1);
        @(negedge clock);
        set_id(1'b1, 5'd9, 5'd2, 5'd11, 32'h0, 32'h2, 2'b00, 1'b0);
        #1 chk("ex_haz_stall_id", 32'(stall_id), 32'd1);
        tick;
        chk("ex_haz_count", 32'(stall_count), 32'd2);
        @(negedge clock);
        set_fwd(1'b1, 1'b1, 5'd9, 32'h0, 1'b0, 5'd0, 32'h0);
        #1 chk("mem_haz_stall_id", 32'(stall_id), 32'd1);
        tick;
        chk("mem_haz_valid", 32'(ex_valid), 32'd0);
        chk("mem_haz_count", 32'(stall_count), 32'd3);

        // Keep the hazard up long enough to saturate the 3-bit counter.
        repeat (6) tick;
        chk("sat_count", 32'(stall_count), 32'd7);
        @(negedge clock);
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h5678);
        tick;
        chk("sat_release_rs", ex_rs_val, 32'h5678);
        chk("sat_release_count", 32'(stall_count), 32'd7);

        // Asynchronous reset mid-stream.
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        chk("arst_valid", 32'(ex_valid), 32'd0);
        chk("arst_rs", ex_rs_val, 32'd0);
        chk("arst_count", 32'(stall_count), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        set_fwd(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        set_id(1'b1, 5'd4, 5'd0, 5'd12, 32'hABCD, 32'h0, 2'b00, 1'b0);
        tick;
        chk("post_rst_valid", 32'(ex_valid), 32'd1);
        chk("post_rst_rs", ex_rs_val, 32'hABCD);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Decode-to-execute pipeline register. It sits directly downstream of the register file and captures rs/rt read data, immediate, control and PC into the execute stage.
- Applies operand forwarding from EX/MEM and MEM/WB, detects load-use hazards and inserts bubbles.
- Handles flush on taken branch/jump and back-pressure from execute.
- Keeps a saturating stall-cycle counter for debug.

Parameters:
- CTRL_W, 8, width of opaque ALU/memory control bundle passed through
- STALL_CNT_W, 16, width of stall-cycle counter

Ports:
- clock  in  1  pipeline clock; all state updates on posedge
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  decode holds a valid instruction
- id_rs_addr, id_rt_addr, id_rd_addr  in  5 each  register specifiers
- id_rs_data, id_rt_data  in  32 each  register-file read data
- id_imm  in  32  sign/zero-extended immediate
- id_pc  in  32  PC+4 of decoded instruction
- id_jump  in  2  jump code; 2'b11 = jal (rs_data carries J-type target)
- id_ctrl  in  CTRL_W  execute control bundle
- id_reg_write, id_mem_read  in  1 each  writeback enable, load flag
- exmem_reg_write  in  1  EX/MEM result will be written
- exmem_mem_read  in  1  EX/MEM holds a load
- exmem_rd  in  5  EX/MEM destination
- exmem_result  in  32  EX/MEM ALU result
- memwb_reg_write  in  1  MEM/WB write enable
- memwb_rd  in  5  MEM/WB destination
- memwb_result  in  32  MEM/WB writeback data
- flush  in  1  taken branch/jump; kill instruction in decode
- ex_ready  in  1  execute accepts new instruction this cycle
- stall_id  out  1  hold PC and IF/ID (combinational)
- ex_valid  out  1  execute-stage instruction valid
- ex_rs_val, ex_rt_val  out  32 each  forwarded operands
- ex_rs_addr, ex_rt_addr, ex_rd_addr  out  5 each  registered specifiers
- ex_imm, ex_pc  out  32 each  registered immediate / PC
- ex_jump  out  2  registered jump code
- ex_ctrl  out  CTRL_W  registered control
- ex_reg_write, ex_mem_read  out  1 each  registered; forced 0 when bubble
- stall_count  out  STALL_CNT_W  saturating count of bubble cycles

Behaviour:
- Reset: all ex_* outputs 0, ex_valid 0, stall_count 0, state RUN.
- Forwarding, per operand (combinational on id side):
  - Register 0 is never forwarded.
  - Priority: exmem (reg_write, not mem_read, rd match) over memwb (reg_write, rd match) over id_*_data.
  - When id_jump==2'b11, rs operand is id_rs_data unmodified (no forwarding).
- Load-use hazard, when id_valid and nonzero rs/rt match:
  - ex_rd_addr while ex_valid && ex_mem_read: 2-cycle hazard.
  - exmem_rd while exmem_mem_read && exmem_reg_write: 1-cycle hazard.
  - rs match is ignored when id_jump==2'b11.
- stall_id = (hazard || (ex_valid && !ex_ready)) && !flush.
- FSM states: RUN, BUBBLE, HOLD.
  - RUN: if flush, load a bubble (ex_valid 0, ex_reg_write 0, ex_mem_read 0; other fields don't-care). Else if ex_valid && !ex_ready, go to HOLD and keep all ex_* unchanged. Else if hazard, load a bubble, stall_count+1, go to BUBBLE. Else capture id_* with forwarded operands; ex_valid=id_valid.
  - BUBBLE: re-evaluate exactly as RUN. A remaining hazard keeps inserting bubbles; return to RUN once there is no hazard.
  - HOLD: outputs frozen while !ex_ready. flush in HOLD does not kill the held instruction, only the one in decode. When ex_ready rises, act as RUN on the same edge.
- Latency: 1 cycle id->ex when no hazard.
- Held or bubbled instructions never update ex_* from a stale id_*. When hazard and flush coincide, flush wins and no stall is counted.
- stall_count saturates at all-ones; it is cleared only by reset.
- reset_n low mid-operation clears immediately (async). First capture occurs on the first posedge after deassertion.

Test Plan:
- Back-to-back: add r3=r1+r2 then sub r4=r3-r5, with exmem_rd=3 and exmem_result=32'h10 -> ex_rs_val=32'h10 on the second instruction, no stall.
- Both EX/MEM and MEM/WB write r7 (0xAA vs 0xBB) -> ex_rs_val=0xAA.
- lw r8 then add using r8 -> stall_id high 1 cycle, ex_valid=0 one cycle, stall_count=1. The add later captures memwb_result=0x1234 for r8.
- Destination r0 matches, exmem_result=0xFFFF -> operand stays id_rs_data, no stall.
- ex_ready low 3 cycles with valid ex -> ex_* frozen, stall_id high 3 cycles. flush during hold -> decode killed, held instruction issues intact.
- jal (id_jump=2'b11, id_rs_data=0x0040_0010) with exmem_rd=rs_addr -> ex_rs_val=0x0040_0010. Assert reset_n low mid-stream -> outputs zero immediately.
